// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver for the SOC IO page.
// The rx line is synchronized, each bit is sampled at its middle using one
// cycle counter, bytes are assembled LSB first and buffered for the CPU.
// Build option UART_RX_FIFO_EN: when defined the buffer is a FIFO_DEPTH-entry
// first-word-fall-through FIFO; when undefined a single holding register is
// used and FIFO_DEPTH has no effect on the buffer.
module uart_receiver #(
    parameter int clk_freq_hz = 25000000,
    parameter int baud_rate   = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_rx,
    input  logic       i_ready,
    input  logic       i_clr_err,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int DIV   = clk_freq_hz / baud_rate;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_receiver: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic             rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic             push, frame_set, pop, ovr_set;

    // Two-flop synchronizer for the asynchronous rx line (idles high).
    always_comb begin
        rx_meta_d = i_rx;
        rx_s_d    = rx_meta_q;
    end

    // Synchronizer flops reset to the idle line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
        end
    end

    // Frame state machine: half-bit check of the start bit, then full-bit steps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // A line held low must go high again before a new start is accepted.
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receiver state registers; a reset mid-frame abandons the partial byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_OCC = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          fifo_full, wr_en;

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        fifo_full = (count_q == FULL_OCC);
        pop       = (count_q != '0) && i_ready;
        wr_en     = push && (!fifo_full || pop);
        ovr_set   = push && fifo_full && !pop;
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = count_q;
        if (wr_en && !pop) count_d = count_q + OCC_ONE;
        else if (pop && !wr_en) count_d = count_q - OCC_ONE;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observable while the entry is occupied.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign o_valid = (count_q != '0);
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : 8'h00;
`else
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;

    // Holding register: a push while popping replaces the byte, otherwise full drops it.
    always_comb begin
        pop     = full_q && i_ready;
        hold_d  = hold_q;
        full_d  = full_q;
        ovr_set = 1'b0;
        if (push) begin
            if (!full_q || pop) begin
                hold_d = shift_q;
                full_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q <= 8'h00;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign o_valid = full_q;
    assign o_data  = hold_q;
`endif

    // Sticky error flags: a set event wins over a simultaneous clear.
    always_comb begin
        frame_err_d = frame_set ? 1'b1 : (i_clr_err ? 1'b0 : frame_err_q);
        overrun_d   = ovr_set   ? 1'b1 : (i_clr_err ? 1'b0 : overrun_q);
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule
